// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline boundary register with valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush and a saturating stall counter.
module mem_wb_pipe_reg #(
  parameter int DATA_W      = 64,
  parameter int RD_W        = 5,
  parameter int CTRL_W      = 1,
  parameter int SKID        = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RD_W-1:0]        Rd_in,
  input  logic [DATA_W-1:0]      Dw_in,
  input  logic [CTRL_W-1:0]      control_in,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RD_W-1:0]        Rd_out,
  output logic [DATA_W-1:0]      Dw_out,
  output logic [CTRL_W-1:0]      control_out,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam bit use_skid = (SKID != 0);
  localparam logic [STALL_CNT_W-1:0] stall_one = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic              main_valid;
  logic [RD_W-1:0]   main_rd;
  logic [DATA_W-1:0] main_dw;
  logic [CTRL_W-1:0] main_ctrl;

  logic              skid_valid;
  logic [RD_W-1:0]   skid_rd;
  logic [DATA_W-1:0] skid_dw;
  logic [CTRL_W-1:0] skid_ctrl;

  logic accept;
  logic pop;

  // With the skid buffer in_ready comes straight from a flop, breaking the
  // combinational out_ready -> in_ready path back into the MEM stage.
  always_comb begin
    in_ready = 1'b0;
    if (use_skid) begin
      in_ready = ~skid_valid;
    end else begin
      in_ready = ~main_valid | out_ready;
    end
    accept = in_valid & in_ready;
    pop    = main_valid & out_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      main_rd    <= '0;
      main_dw    <= '0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_rd    <= '0;
      skid_dw    <= '0;
      skid_ctrl  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (pop) begin
      if (skid_valid) begin
        main_rd    <= skid_rd;
        main_dw    <= skid_dw;
        main_ctrl  <= skid_ctrl;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_rd   <= Rd_in;
        main_dw   <= Dw_in;
        main_ctrl <= control_in;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      // A held main entry pushes the newcomer into the skid slot (FIFO order).
      if (!main_valid) begin
        main_valid <= 1'b1;
        main_rd    <= Rd_in;
        main_dw    <= Dw_in;
        main_ctrl  <= control_in;
      end else if (use_skid) begin
        skid_valid <= 1'b1;
        skid_rd    <= Rd_in;
        skid_dw    <= Dw_in;
        skid_ctrl  <= control_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + stall_one;
    end
  end

  assign out_valid   = main_valid;
  assign Rd_out      = main_rd;
  assign Dw_out      = main_dw;
  assign control_out = main_valid ? main_ctrl : '0;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed bench for mem_wb_pipe_reg: skid, no-skid and narrow stall-counter
// instances share one stimulus set; each check targets the relevant instance.
module tb_mem_wb_pipe_reg;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [4:0]  Rd_in;
  logic [63:0] Dw_in;
  logic [0:0]  control_in;
  logic        flush;
  logic        out_ready;

  logic        ir1, ov1, ir0, ov0, ir3, ov3;
  logic [4:0]  rd1, rd0, rd3;
  logic [63:0] dw1, dw0, dw3;
  logic [0:0]  c1, c0, c3;
  logic [15:0] st1, st0;
  logic [2:0]  st3;

  int assertions = 0;
  int failures   = 0;

  mem_wb_pipe_reg #(.SKID(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
    .Rd_in(Rd_in), .Dw_in(Dw_in), .control_in(control_in), .flush(flush),
    .out_valid(ov1), .out_ready(out_ready), .Rd_out(rd1), .Dw_out(dw1),
    .control_out(c1), .stall_cnt(st1)
  );

  mem_wb_pipe_reg #(.SKID(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0),
    .Rd_in(Rd_in), .Dw_in(Dw_in), .control_in(control_in), .flush(flush),
    .out_valid(ov0), .out_ready(out_ready), .Rd_out(rd0), .Dw_out(dw0),
    .control_out(c0), .stall_cnt(st0)
  );

  mem_wb_pipe_reg #(.SKID(1), .STALL_CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir3),
    .Rd_in(Rd_in), .Dw_in(Dw_in), .control_in(control_in), .flush(flush),
    .out_valid(ov3), .out_ready(out_ready), .Rd_out(rd3), .Dw_out(dw3),
    .control_out(c3), .stall_cnt(st3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  rd;
    logic [63:0] dw;
    logic        c;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic [4:0]  e_rd;
    logic [63:0] e_dw;
    logic        e_c;
    logic        e_ir;
    logic [15:0] e_st;
  } vec_t;

  vec_t vecs[16];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic iv, input logic [4:0] rd, input logic [63:0] dw,
                                input logic c, input logic ordy, input logic fl);
    in_valid   = iv;
    Rd_in      = rd;
    Dw_in      = dw;
    control_in = c;
    out_ready  = ordy;
    flush      = fl;
  endtask

  task automatic reset_pulse();
    apply_stimulus(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // iv rd dw c ordy fl | ov rd dw c ir st  (outputs after the edge)
    vecs[0]  = '{1'b1, 5'd3,  64'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3,  64'hA5, 1'b1, 1'b1, 16'd0};
    vecs[1]  = '{1'b0, 5'd0,  64'h0,  1'b0, 1'b1, 1'b0, 1'b0, 5'd3,  64'hA5, 1'b0, 1'b1, 16'd0};
    vecs[2]  = '{1'b1, 5'd1,  64'h11, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1,  64'h11, 1'b1, 1'b1, 16'd0};
    vecs[3]  = '{1'b1, 5'd2,  64'h22, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1,  64'h11, 1'b1, 1'b0, 16'd1};
    vecs[4]  = '{1'b1, 5'd9,  64'h99, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1,  64'h11, 1'b1, 1'b0, 16'd2};
    vecs[5]  = '{1'b0, 5'd0,  64'h0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd2,  64'h22, 1'b1, 1'b1, 16'd2};
    vecs[6]  = '{1'b0, 5'd0,  64'h0,  1'b0, 1'b1, 1'b0, 1'b0, 5'd2,  64'h22, 1'b0, 1'b1, 16'd2};
    vecs[7]  = '{1'b1, 5'd4,  64'h44, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4,  64'h44, 1'b1, 1'b1, 16'd2};
    vecs[8]  = '{1'b1, 5'd5,  64'h55, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4,  64'h44, 1'b1, 1'b0, 16'd3};
    vecs[9]  = '{1'b1, 5'd6,  64'h66, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4,  64'h44, 1'b0, 1'b1, 16'd4};
    vecs[10] = '{1'b1, 5'd7,  64'h77, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4,  64'h44, 1'b0, 1'b1, 16'd4};
    vecs[11] = '{1'b0, 5'd0,  64'h0,  1'b0, 1'b1, 1'b0, 1'b0, 5'd4,  64'h44, 1'b0, 1'b1, 16'd4};
    vecs[12] = '{1'b1, 5'd8,  64'h88, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8,  64'h88, 1'b1, 1'b1, 16'd4};
    vecs[13] = '{1'b1, 5'd10, 64'hAA, 1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 64'hAA, 1'b0, 1'b1, 16'd4};
    vecs[14] = '{1'b1, 5'd11, 64'hBB, 1'b1, 1'b1, 1'b0, 1'b1, 5'd11, 64'hBB, 1'b1, 1'b1, 16'd4};
    vecs[15] = '{1'b0, 5'd0,  64'h0,  1'b0, 1'b1, 1'b0, 1'b0, 5'd11, 64'hBB, 1'b0, 1'b1, 16'd4};

    apply_stimulus(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    check_output("reset_out_valid", {63'd0, ov1}, 64'd0);
    check_output("reset_in_ready", {63'd0, ir1}, 64'd1);
    check_output("reset_rd_out", {59'd0, rd1}, 64'd0);
    check_output("reset_dw_out", dw1, 64'd0);
    check_output("reset_stall_cnt", {48'd0, st1}, 64'd0);
    reset = 1'b1;

    // Skid configuration: stream, skid fill/drain, flush, accept-with-pop
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].iv, vecs[i].rd, vecs[i].dw, vecs[i].c, vecs[i].ordy, vecs[i].fl);
      @(posedge clk);
      #1;
      check_output($sformatf("v%0d_out_valid", i), {63'd0, ov1}, {63'd0, vecs[i].e_ov});
      check_output($sformatf("v%0d_rd_out", i), {59'd0, rd1}, {59'd0, vecs[i].e_rd});
      check_output($sformatf("v%0d_dw_out", i), dw1, vecs[i].e_dw);
      check_output($sformatf("v%0d_control_out", i), {63'd0, c1}, {63'd0, vecs[i].e_c});
      check_output($sformatf("v%0d_in_ready", i), {63'd0, ir1}, {63'd0, vecs[i].e_ir});
      check_output($sformatf("v%0d_stall_cnt", i), {48'd0, st1}, {48'd0, vecs[i].e_st});
    end

    // No-skid configuration: back-to-back throughput of one entry per cycle
    reset_pulse();
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 5'(i + 1), 64'(256 + i), 1'b1, 1'b1, 1'b0);
      #1;
      check_output($sformatf("s0_in_ready_%0d", i), {63'd0, ir0}, 64'd1);
      @(posedge clk);
      #1;
      check_output($sformatf("s0_out_valid_%0d", i), {63'd0, ov0}, 64'd1);
      check_output($sformatf("s0_rd_out_%0d", i), {59'd0, rd0}, 64'(i + 1));
      check_output($sformatf("s0_dw_out_%0d", i), dw0, 64'(256 + i));
    end
    apply_stimulus(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_output("s0_in_ready_held", {63'd0, ir0}, 64'd0);
    out_ready = 1'b1;
    #1;
    check_output("s0_in_ready_pop", {63'd0, ir0}, 64'd1);
    @(posedge clk);
    #1;
    check_output("s0_drained", {63'd0, ov0}, 64'd0);
    check_output("s0_stall_cnt", {48'd0, st0}, 64'd0);

    // Saturating stall counter on the 3-bit instance
    reset_pulse();
    apply_stimulus(1'b1, 5'd7, 64'h77, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("sat_stall_%0d", j), {61'd0, st3}, (j < 7) ? 64'(j) : 64'd7);
    end
    check_output("sat_out_valid", {63'd0, ov3}, 64'd1);
    check_output("wide_stall_cnt", {48'd0, st1}, 64'd12);

    // Asynchronous reset between edges while stalled
    #2;
    reset = 1'b0;
    #1;
    check_output("areset_out_valid", {63'd0, ov1}, 64'd0);
    check_output("areset_control_out", {63'd0, c1}, 64'd0);
    check_output("areset_stall_cnt", {48'd0, st1}, 64'd0);
    check_output("areset_in_ready", {63'd0, ir1}, 64'd1);
    check_output("areset_rd_out", {59'd0, rd1}, 64'd0);
    check_output("areset_stall3", {61'd0, st3}, 64'd0);
    check_output("areset_s0_in_ready", {63'd0, ir0}, 64'd1);
    apply_stimulus(1'b1, 5'd12, 64'hCC, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_output("held_reset_ignores_input", {63'd0, ov1}, 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("post_reset_accept", {59'd0, rd1}, 64'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe_reg.md
Name: mem_wb_pipe_reg

Overview:
Parametrised MEM->WB pipeline boundary register with a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush and a saturating stall counter. Carries destination register index, write-back data and a control vector ({RegWrite, ...}). Bubbles always drive zero control, so a stalled, flushed or empty stage can never commit a register write. Sits between the MEM stage and register-file write port; it is the drop-in successor of the fixed-width MEM/WB register.

Parameters:
DATA_W, 64, width of write-back data Dw
RD_W, 5, width of destination register index Rd
CTRL_W, 1, width of control vector; bit 0 = RegWrite
SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single entry (combinational in_ready)
STALL_CNT_W, 16, width of the saturating stall counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous reset, active-low (0 = in reset)
in_valid  input  1  MEM stage presents a valid entry
in_ready  output  1  stage can accept an entry this cycle
Rd_in  input  RD_W  destination register index
Dw_in  input  DATA_W  write-back data
control_in  input  CTRL_W  control vector
flush  input  1  synchronous kill of all held entries
out_valid  output  1  WB entry valid
out_ready  input  1  WB consumer accepts entry
Rd_out  output  RD_W  held Rd
Dw_out  output  DATA_W  held Dw
control_out  output  CTRL_W  held control, forced 0 when out_valid=0
stall_cnt  output  STALL_CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (reset=0, async): out_valid=0, Rd_out=0, Dw_out=0, control_out=0, stall_cnt=0, skid entry invalid, in_ready=1. Inputs are ignored while reset=0.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready. Latency is 1 cycle: an entry accepted at edge N appears on the outputs after edge N.
- SKID=0: in_ready = ~out_valid | out_ready (combinational). On accept, the main register loads. On pop with no accept, out_valid clears.
- SKID=1: in_ready = ~skid_valid, registered with no combinational path from out_ready.
  - Accept while main is empty, or main is popping with the skid empty: load main.
  - Accept while main is held (valid, not popping): load the skid, and in_ready drops to 0 on the next cycle.
  - Pop with skid valid: skid moves to main, skid clears, in_ready returns to 1.
  - Order is strictly FIFO. No entry is duplicated or dropped except by flush.
- Flush (synchronous): at the edge, out_valid=0 and skid_valid=0. Any concurrent accept is discarded; flush wins. in_ready=1 on the next cycle. Data registers may keep stale values. control_out reads 0 immediately on the following cycle.
- control_out = out_valid ? held_control : 0, applied to the whole vector.
- Rd_out and Dw_out hold their last value when invalid. They are not cleared except by reset.
- stall_cnt increments by 1 per cycle with out_valid & ~out_ready. It saturates at 2^STALL_CNT_W-1, never wraps, and is cleared only by reset.
- Simultaneous accept and pop on a full skid configuration cannot occur, because in_ready=0.
- Simultaneous accept and pop with main valid and skid empty: the new entry replaces main and out_valid stays 1.
- Reset asserted mid-transfer: all state clears immediately, without waiting for clk.

Test Plan:
1. Reset release, then stream Rd=5'd3/Dw=64'hA5 with control=1, out_ready=1 -> next cycle Rd_out=3, Dw_out=64'hA5, control_out=1, out_valid=1. stall_cnt stays 0.
2. SKID=1: push E1 (Rd=1), E2 (Rd=2) on consecutive cycles with out_ready=0 -> out_valid=1 with Rd_out=1, in_ready=0 from cycle 3. Raise out_ready: Rd_out=1 then Rd_out=2 on successive cycles. No loss, and stall_cnt=2.
3. Flush while main and skid are both valid and in_valid=1 -> next cycle out_valid=0, control_out=0, in_ready=1. The discarded input never appears on the outputs.
4. SKID=0: out_valid=1, out_ready=1, in_valid=1 every cycle for 10 entries -> back-to-back throughput of one entry per cycle, in_ready=1 throughout.
5. STALL_CNT_W=3, hold out_ready=0 for 12 cycles with valid data -> stall_cnt saturates at 7 and stays there.
6. Assert reset=0 asynchronously between clock edges mid-stall -> out_valid, control_out and stall_cnt go to 0 before the next clk edge, and in_ready=1.
